// File: rtl/viterbi_decoder.sv
// viterbi_decoder
// Hard-decision Viterbi decoder for the rate-1/2, K=3 (7,5 octal) convolutional
// code. Four-state add-compare-select core with register-exchange survivors.
// One 2-bit code symbol is accepted per valid cycle. Once D symbols have been
// accepted, every accepted symbol yields one decoded bit on the following cycle.
//
// Parameters
//   D     survivor depth in symbols (4..64)
//   PM_W  path-metric width in bits (4..8)
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset, clears all state
//   valid_in   data_in carries a code symbol this cycle
//   data_in    code symbol: [1] = c1 (g=111), [0] = c0 (g=101)
//   valid_out  data_out carries a decoded bit this cycle
//   data_out   decoded data bit (holds between outputs)
module viterbi_decoder #(
    parameter int D    = 16,
    parameter int PM_W = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_in,
    input  logic [1:0] data_in,
    output logic       valid_out,
    output logic       data_out
);

    localparam int              CW      = $clog2(D + 1);
    localparam logic [PM_W-1:0] PM_INIT = {1'b1, {(PM_W-1){1'b0}}};
    localparam logic [PM_W-1:0] PM_MAX  = {PM_W{1'b1}};
    localparam logic [CW-1:0]   CNT_MAX = CW'(D);
    localparam logic [CW-1:0]   CNT_OUT = CW'(D - 1);

    // Hamming distance between the received symbol and the symbol the encoder
    // would emit from state st = {s1,s0} on input u.
    function automatic logic [1:0] branch_metric(input logic [1:0] sym,
                                                 input logic [1:0] st,
                                                 input logic       u);
        logic [1:0] diff;
        diff = sym ^ {u ^ st[0] ^ st[1], u ^ st[1]};
        return {1'b0, diff[1]} + {1'b0, diff[0]};
    endfunction

    logic [PM_W-1:0] pm_r   [4];
    logic [D-1:0]    surv_r [4];
    logic [CW-1:0]   cnt_r;
    logic            valid_out_r;
    logic            data_out_r;

    logic [PM_W:0]   cand_s      [4];
    logic [1:0]      pred_s      [4];
    logic [D-1:0]    surv_next_s [4];
    logic [PM_W-1:0] norm_s      [4];
    logic [PM_W:0]   min_s;
    logic [1:0]      best_s;
    logic            dec_s;

    assign valid_out = valid_out_r;
    assign data_out  = data_out_r;

    // Add-compare-select: state n = {n1,n0} is reached with input n0 from
    // {0,n1} or {1,n1}; the lower-index predecessor wins ties.
    always_comb begin
        logic [1:0]    st_n;
        logic [1:0]    lo_st;
        logic [1:0]    hi_st;
        logic [PM_W:0] c_lo;
        logic [PM_W:0] c_hi;
        st_n  = 2'b00;
        lo_st = 2'b00;
        hi_st = 2'b00;
        c_lo  = {(PM_W+1){1'b0}};
        c_hi  = {(PM_W+1){1'b0}};
        for (int n = 0; n < 4; n++) begin
            st_n  = 2'(n);
            lo_st = {1'b0, st_n[1]};
            hi_st = {1'b1, st_n[1]};
            c_lo  = {1'b0, pm_r[lo_st]} + {{(PM_W-1){1'b0}}, branch_metric(data_in, lo_st, st_n[0])};
            c_hi  = {1'b0, pm_r[hi_st]} + {{(PM_W-1){1'b0}}, branch_metric(data_in, hi_st, st_n[0])};
            if (c_hi < c_lo) begin
                cand_s[n] = c_hi;
                pred_s[n] = hi_st;
            end else begin
                cand_s[n] = c_lo;
                pred_s[n] = lo_st;
            end
            surv_next_s[n] = {surv_r[pred_s[n]][D-2:0], st_n[0]};
        end
    end

    // Normalisation against the smallest candidate, saturation, and selection
    // of the best state (lowest index holding a zero metric).
    always_comb begin
        logic [PM_W:0] diff;
        diff  = {(PM_W+1){1'b0}};
        min_s = cand_s[0];
        for (int n = 1; n < 4; n++) begin
            if (cand_s[n] < min_s) begin
                min_s = cand_s[n];
            end else begin
                min_s = min_s;
            end
        end
        for (int n = 0; n < 4; n++) begin
            diff = cand_s[n] - min_s;
            if (diff > {1'b0, PM_MAX}) begin
                norm_s[n] = PM_MAX;
            end else begin
                norm_s[n] = diff[PM_W-1:0];
            end
        end
        if (norm_s[0] == {PM_W{1'b0}}) begin
            best_s = 2'd0;
        end else if (norm_s[1] == {PM_W{1'b0}}) begin
            best_s = 2'd1;
        end else if (norm_s[2] == {PM_W{1'b0}}) begin
            best_s = 2'd2;
        end else begin
            best_s = 2'd3;
        end
        dec_s = surv_next_s[best_s][D-1];
    end

    // Metric, survivor and counter update on each accepted symbol; the output
    // registers carry the decision of the symbol accepted on the previous edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                pm_r[i]   <= (i == 0) ? {PM_W{1'b0}} : PM_INIT;
                surv_r[i] <= {D{1'b0}};
            end
            cnt_r       <= {CW{1'b0}};
            valid_out_r <= 1'b0;
            data_out_r  <= 1'b0;
        end else if (valid_in) begin
            for (int i = 0; i < 4; i++) begin
                pm_r[i]   <= norm_s[i];
                surv_r[i] <= surv_next_s[i];
            end
            if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + CW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            // This symbol brings the count to D or beyond: emit a bit.
            valid_out_r <= (cnt_r >= CNT_OUT);
            if (cnt_r >= CNT_OUT) begin
                data_out_r <= dec_s;
            end else begin
                data_out_r <= data_out_r;
            end
        end else begin
            valid_out_r <= 1'b0;
            data_out_r  <= data_out_r;
        end
    end

endmodule
